// File: rtl/apb_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer_pkg
// Brief    : Register map, CTRL/STATUS bit positions and handshake states
//            shared by the APB timer and its counting core.
// Revision : 1.0 - initial release
// ============================================================================
package apb_timer_pkg;

    // Word index into the register window (byte offset = index * 4)
    localparam logic [2:0] IDX_CTRL   = 3'd0;  // 0x00
    localparam logic [2:0] IDX_TCNT   = 3'd1;  // 0x04
    localparam logic [2:0] IDX_PSC    = 3'd2;  // 0x08
    localparam logic [2:0] IDX_ARR    = 3'd3;  // 0x0C
    localparam logic [2:0] IDX_STATUS = 3'd4;  // 0x10

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_INT_EN = 2;
    localparam int STATUS_UIF  = 0;

    typedef enum logic {
        W1 = 1'b0,
        W2 = 1'b1
    } hs_state_e;

endpackage
`default_nettype wire

// File: rtl/timer_core.sv
`default_nettype none
// ============================================================================
// Module   : timer_core
// Brief    : Prescaled up-counter with auto-reload and sticky update flag.
// Revision : 1.0 - initial release
// ============================================================================
module timer_core
    import apb_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] psc_i,
    input  logic [CNT_W-1:0] arr_i,
    input  logic             uif_clr_i,
    output logic [CNT_W-1:0] tcnt_o,
    output logic             uif_o
);

    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             uif_q, uif_d;
    logic             tick;
    logic             wrap;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
            tcnt_q <= '0;
            uif_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tcnt_q <= tcnt_d;
            uif_q  <= uif_d;
        end
    end

    // >= rather than == so a PSC/ARR reduced below the live count wraps at once
    always_comb begin
        pcnt_d = pcnt_q;
        tcnt_d = tcnt_q;
        uif_d  = uif_q;
        tick   = 1'b0;
        wrap   = 1'b0;
        if (clr_i) begin
            pcnt_d = '0;
            tcnt_d = '0;
        end else if (en_i) begin
            if (pcnt_q >= psc_i) begin
                pcnt_d = '0;
                tick   = 1'b1;
            end else begin
                pcnt_d = pcnt_q + CNT_W'(1);
            end
            if (tick) begin
                if (tcnt_q >= arr_i) begin
                    tcnt_d = '0;
                    wrap   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
        end
        // A set in the same cycle as a W1C wins
        if (wrap) begin
            uif_d = 1'b1;
        end else if (uif_clr_i) begin
            uif_d = 1'b0;
        end
    end

    assign tcnt_o = tcnt_q;
    assign uif_o  = uif_q;

endmodule
`default_nettype wire

// File: rtl/apb_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer
// Brief    : APB slave timer with one wait state per transfer, register file,
//            read mux and level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
);

    hs_state_e        state_q, state_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             en_q, en_d;
    logic             int_en_q, int_en_d;
    logic [CNT_W-1:0] psc_q, psc_d;
    logic [CNT_W-1:0] arr_q, arr_d;

    logic [2:0]       addr_idx;
    logic             wr_commit;
    logic             clr_pulse;
    logic             uif_clr;
    logic [31:0]      rd_mux;
    logic [CNT_W-1:0] tcnt;
    logic             uif;
    logic             unused_bits;

    assign addr_idx    = PADDR[4:2];
    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA};

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= W1;
            prdata_q <= '0;
            en_q     <= 1'b0;
            int_en_q <= 1'b0;
            psc_q    <= '0;
            arr_q    <= '0;
        end else begin
            state_q  <= state_d;
            prdata_q <= prdata_d;
            en_q     <= en_d;
            int_en_q <= int_en_d;
            psc_q    <= psc_d;
            arr_q    <= arr_d;
        end
    end

    // Read data is captured on the W1 edge and presented during W2
    always_comb begin
        state_d   = state_q;
        prdata_d  = prdata_q;
        wr_commit = 1'b0;
        case (state_q)
            W1: begin
                if (PSEL && PENABLE) begin
                    state_d  = W2;
                    prdata_d = rd_mux;
                end
            end
            W2: begin
                state_d   = W1;
                wr_commit = PSEL && PENABLE && PWRITE;
            end
            default: state_d = W1;
        endcase
    end

    always_comb begin
        en_d      = en_q;
        int_en_d  = int_en_q;
        psc_d     = psc_q;
        arr_d     = arr_q;
        clr_pulse = 1'b0;
        uif_clr   = 1'b0;
        if (wr_commit) begin
            case (addr_idx)
                IDX_CTRL: begin
                    en_d      = PWDATA[CTRL_EN];
                    int_en_d  = PWDATA[CTRL_INT_EN];
                    clr_pulse = PWDATA[CTRL_CLR];
                end
                IDX_PSC:    psc_d   = PWDATA[CNT_W-1:0];
                IDX_ARR:    arr_d   = PWDATA[CNT_W-1:0];
                IDX_STATUS: uif_clr = PWDATA[STATUS_UIF];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr_idx)
            IDX_CTRL: begin
                rd_mux[CTRL_EN]     = en_q;
                rd_mux[CTRL_INT_EN] = int_en_q;
            end
            IDX_TCNT:   rd_mux[CNT_W-1:0] = tcnt;
            IDX_PSC:    rd_mux[CNT_W-1:0] = psc_q;
            IDX_ARR:    rd_mux[CNT_W-1:0] = arr_q;
            IDX_STATUS: rd_mux[STATUS_UIF] = uif;
            default: ;
        endcase
    end

    timer_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .en_i      (en_q),
        .clr_i     (clr_pulse),
        .psc_i     (psc_q),
        .arr_i     (arr_q),
        .uif_clr_i (uif_clr),
        .tcnt_o    (tcnt),
        .uif_o     (uif)
    );

    assign PRDATA = prdata_q;
    assign PREADY = (state_q == W2);
    assign irq    = uif & int_en_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_timer
// Brief    : Directed self-checking bench for apb_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_timer;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_seq [9] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2,
                                 32'd2, 32'd3, 32'd3, 32'd0};

    apb_timer #(
        .CNT_W (32)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the commit edge
    task automatic apb(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        @(negedge PCLK);
        PENABLE = 1'b1;
        check("pready_access1", {31'b0, PREADY}, 32'd0);
        @(negedge PCLK);
        check("pready_access2", {31'b0, PREADY}, 32'd1);
        rdata = PRDATA;
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        check("pready_idle", {31'b0, PREADY}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        apb(1'b1, addr, data, dummy);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] data;
        apb(1'b0, addr, 32'd0, data);
        check(tag, data, exp);
    endtask

    initial begin
        PRESET  = 1'b1;
        PADDR   = '0;
        PWDATA  = '0;
        PWRITE  = 1'b0;
        PENABLE = 1'b0;
        PSEL    = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pready", {31'b0, PREADY}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Every offset reads zero after reset
        for (int a = 0; a < 8; a++) begin
            rd($sformatf("rst_read_0x%02h", a * 4), 32'(a * 4), 32'd0);
        end
        check("rst_irq_after_reads", {31'b0, irq}, 32'd0);

        // PSC=1, ARR=3: TCNT steps every other cycle, UIF after 8 cycles
        wr(32'h08, 32'd1);
        wr(32'h0C, 32'd3);
        wr(32'h00, 32'h5);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("tcnt_seq%0d", k), dut.u_core.tcnt_o, exp_seq[k]);
            check($sformatf("irq_seq%0d", k), {31'b0, irq}, (k == 8) ? 32'd1 : 32'd0);
            if (k < 8) @(negedge PCLK);
        end

        // CLR+EN restarts the count; CLR and INT_EN read back as 0
        wr(32'h00, 32'h3);
        rd("tcnt_after_clr", 32'h04, 32'd0);
        rd("ctrl_readback", 32'h00, 32'd1);
        rd("status_sticky", 32'h10, 32'd1);
        check("irq_masked", {31'b0, irq}, 32'd0);

        // PSC=0, ARR=0: every cycle sets UIF, so a W1C always collides
        wr(32'h08, 32'd0);
        wr(32'h0C, 32'd0);
        wr(32'h00, 32'h5);
        check("irq_enabled", {31'b0, irq}, 32'd1);
        wr(32'h10, 32'd1);
        check("uif_set_wins", {31'b0, dut.u_core.uif_o}, 32'd1);
        rd("status_set_wins", 32'h10, 32'd1);
        wr(32'h00, 32'h4);
        check("irq_before_w1c", {31'b0, irq}, 32'd1);
        wr(32'h10, 32'd1);
        check("irq_after_w1c", {31'b0, irq}, 32'd0);
        rd("status_cleared", 32'h10, 32'd0);

        // Stop the count at TCNT=10, then shrink ARR below it
        wr(32'h0C, 32'd100);
        wr(32'h00, 32'h1);
        repeat (7) @(negedge PCLK);
        wr(32'h00, 32'h0);
        check("tcnt_held_10", dut.u_core.tcnt_o, 32'd10);
        rd("tcnt_read_10", 32'h04, 32'd10);
        wr(32'h0C, 32'd5);
        check("uif_before_wrap", {31'b0, dut.u_core.uif_o}, 32'd0);
        wr(32'h00, 32'h1);
        check("tcnt_pre_wrap", dut.u_core.tcnt_o, 32'd10);
        @(negedge PCLK);
        check("tcnt_wrapped", dut.u_core.tcnt_o, 32'd0);
        check("uif_on_wrap", {31'b0, dut.u_core.uif_o}, 32'd1);
        rd("arr_readback", 32'h0C, 32'd5);

        // Reset during W2 of a PSC write
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h08;
        PWDATA  = 32'h55;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        check("rst_mid_w2_pready", {31'b0, PREADY}, 32'd1);
        #2 PRESET = 1'b1;
        #1;
        check("rst_async_pready", {31'b0, PREADY}, 32'd0);
        check("rst_async_prdata", PRDATA, 32'd0);
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        check("rst_irq_again", {31'b0, irq}, 32'd0);
        rd("psc_after_rst", 32'h08, 32'd0);
        rd("ctrl_after_rst", 32'h00, 32'd0);
        rd("tcnt_after_rst", 32'h04, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
